// File: rtl/atcaxi2tluh500_source_alloc_if.sv
`default_nettype none
// ============================================================================
// Module   : atcaxi2tluh500_source_alloc_if
// Brief    : Allocate/release handshake and status bundle for the source-ID
//            allocator of the AXI-to-TileLink-UH bridge.
// Revision : 1.0 - initial release
// ============================================================================
interface atcaxi2tluh500_source_alloc_if #(
    parameter int N = 4
);
    localparam int W = $clog2(N);

    // Allocation channel
    logic         alloc_valid;
    logic         alloc_ready;
    logic [W-1:0] alloc_id;

    // Release channel
    logic         free_valid;
    logic [W-1:0] free_id;

    // Status and error reporting
    logic [N-1:0] busy;
    logic [W:0]   count;
    logic         full;
    logic         empty;
    logic         err_dfree;
    logic         err_clr;

    // Allocator side
    modport slave (
        output alloc_valid, alloc_id, busy, count, full, empty, err_dfree,
        input  alloc_ready, free_valid, free_id, err_clr
    );

    // Issue/return logic side
    modport master (
        input  alloc_valid, alloc_id, busy, count, full, empty, err_dfree,
        output alloc_ready, free_valid, free_id, err_clr
    );
endinterface
`default_nettype wire

// File: rtl/atcaxi2tluh500_source_alloc.sv
`default_nettype none
// ============================================================================
// Module   : atcaxi2tluh500_source_alloc
// Brief    : Source-ID allocator. Hands out the lowest free TileLink source
//            ID on each accepted allocation and releases it when the matching
//            D-channel response retires. Flags illegal releases (sticky).
// Revision : 1.0 - initial release
// ============================================================================
module atcaxi2tluh500_source_alloc #(
    parameter int N = 4
) (
    input  wire logic                          aclk,
    input  wire logic                          aresetn,
    atcaxi2tluh500_source_alloc_if.slave       bus
);
    localparam int W = $clog2(N);
    localparam logic [W:0] C_FULL_COUNT = (W+1)'(N);

    logic [N-1:0] r_busy;
    logic [W:0]   r_count;
    logic         r_err_dfree;

    logic [N-1:0] w_free_oh;
    logic [W-1:0] w_alloc_id;
    logic         w_alloc_valid;
    logic         w_alloc_fire;
    logic [N-1:0] w_free_dec;
    logic         w_free_ok;
    logic         w_err_set;
    logic [N-1:0] w_busy_set;
    logic [N-1:0] w_busy_clr;

    // Lowest clear bit of busy as a onehot; all-ones busy yields zero.
    assign w_free_oh     = ~r_busy & (r_busy + 1'b1);
    assign w_alloc_valid = ~(&r_busy);
    assign w_alloc_fire  = w_alloc_valid & bus.alloc_ready;

    // Onehot-to-binary encode of the free slot.
    always_comb begin
        w_alloc_id = '0;
        for (int k = 0; k < N; k++) begin
            if (w_free_oh[k]) begin
                w_alloc_id = w_alloc_id | W'(k);
            end
        end
    end

    // Decode free_id; out-of-range IDs match no bit, so they are never "ok".
    always_comb begin
        w_free_dec = '0;
        for (int k = 0; k < N; k++) begin
            w_free_dec[k] = (bus.free_id == W'(k));
        end
    end

    assign w_free_ok  = bus.free_valid & (|(r_busy & w_free_dec));
    assign w_err_set  = bus.free_valid & ~w_free_ok;
    assign w_busy_set = w_alloc_fire ? w_free_oh  : '0;
    assign w_busy_clr = w_free_ok    ? w_free_dec : '0;

    // Busy vector and outstanding count; set and clear of different bits can
    // coincide because the search never selects a currently-busy bit.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_busy  <= '0;
            r_count <= '0;
        end else begin
            r_busy <= (r_busy | w_busy_set) & ~w_busy_clr;
            case ({w_alloc_fire, w_free_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky illegal-free flag; a new error wins over a clear request.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_err_dfree <= 1'b0;
        end else if (w_err_set) begin
            r_err_dfree <= 1'b1;
        end else if (bus.err_clr) begin
            r_err_dfree <= 1'b0;
        end
    end

    // The count must always track the number of set busy bits.
    a_count_matches_busy : assert property (
        @(posedge aclk) disable iff (!aresetn)
        r_count == (W+1)'($countones(r_busy))
    );

    assign bus.alloc_valid = w_alloc_valid;
    assign bus.alloc_id    = w_alloc_id;
    assign bus.busy        = r_busy;
    assign bus.count       = r_count;
    assign bus.full        = (r_count == C_FULL_COUNT);
    assign bus.empty       = (r_count == '0);
    assign bus.err_dfree   = r_err_dfree;
endmodule
`default_nettype wire

// File: tb/tb_atcaxi2tluh500_source_alloc.sv
`default_nettype none
// ============================================================================
// Module   : tb_atcaxi2tluh500_source_alloc
// Brief    : Directed self-checking bench for the source-ID allocator
//            (one N=4 instance, one N=6 instance for the out-of-range case).
// Revision : 1.0 - initial release
// ============================================================================
module tb_atcaxi2tluh500_source_alloc;
    logic aclk;
    logic aresetn;
    int   checks;
    int   failures;

    atcaxi2tluh500_source_alloc_if #(.N(4)) bus4 ();
    atcaxi2tluh500_source_alloc_if #(.N(6)) bus6 ();

    atcaxi2tluh500_source_alloc #(.N(4)) dut4 (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus4)
    );

    atcaxi2tluh500_source_alloc #(.N(6)) dut6 (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus6)
    );

    // 10 ns clock
    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // Advance one edge; inputs are driven and outputs sampled 1 ns later.
    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        aresetn          = 1'b0;
        bus4.alloc_ready = 1'b0;
        bus4.free_valid  = 1'b0;
        bus4.free_id     = '0;
        bus4.err_clr     = 1'b0;
        bus6.alloc_ready = 1'b0;
        bus6.free_valid  = 1'b0;
        bus6.free_id     = '0;
        bus6.err_clr     = 1'b0;
        #13;
        checks++;
        if (bus4.busy !== 4'b0000) begin failures++; $display("FAIL reset_busy got=%b want=0000", bus4.busy); end
        checks++;
        if (bus4.count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", bus4.count); end
        checks++;
        if ({bus4.empty, bus4.full, bus4.alloc_valid} !== 3'b101) begin
            failures++; $display("FAIL reset_flags empty/full/valid got=%b want=101", {bus4.empty, bus4.full, bus4.alloc_valid});
        end
        checks++;
        if (bus4.alloc_id !== 2'd0) begin failures++; $display("FAIL reset_alloc_id got=%0d want=0", bus4.alloc_id); end
        checks++;
        if (bus4.err_dfree !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", bus4.err_dfree); end
        aresetn = 1'b1;
        step();
    endtask

    task automatic test_fill();
        logic [1:0] exp_id;
        bus4.alloc_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_id = (i < 4) ? 2'(i) : 2'd0;
            checks++;
            if (bus4.alloc_valid !== (i < 4)) begin
                failures++; $display("FAIL fill_valid cycle=%0d got=%b want=%b", i, bus4.alloc_valid, (i < 4));
            end
            checks++;
            if (bus4.alloc_id !== exp_id) begin
                failures++; $display("FAIL fill_id cycle=%0d got=%0d want=%0d", i, bus4.alloc_id, exp_id);
            end
            step();
        end
        bus4.alloc_ready = 1'b0;
        checks++;
        if (bus4.busy !== 4'b1111) begin failures++; $display("FAIL fill_busy got=%b want=1111", bus4.busy); end
        checks++;
        if (bus4.count !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d want=4", bus4.count); end
        checks++;
        if ({bus4.full, bus4.empty} !== 2'b10) begin
            failures++; $display("FAIL fill_flags full/empty got=%b want=10", {bus4.full, bus4.empty});
        end
    endtask

    task automatic test_ooo_release();
        bus4.free_valid = 1'b1;
        bus4.free_id    = 2'd2;
        step();
        checks++;
        if (bus4.busy !== 4'b1011) begin failures++; $display("FAIL ooo_busy1 got=%b want=1011", bus4.busy); end
        checks++;
        if (bus4.alloc_id !== 2'd2) begin failures++; $display("FAIL ooo_reuse_id got=%0d want=2", bus4.alloc_id); end
        bus4.free_id = 2'd0;
        step();
        bus4.free_valid = 1'b0;
        checks++;
        if (bus4.busy !== 4'b1010) begin failures++; $display("FAIL ooo_busy2 got=%b want=1010", bus4.busy); end
        checks++;
        if (bus4.count !== 3'd2) begin failures++; $display("FAIL ooo_count got=%0d want=2", bus4.count); end
        checks++;
        if (bus4.alloc_id !== 2'd0) begin failures++; $display("FAIL ooo_alloc_id got=%0d want=0", bus4.alloc_id); end
        bus4.alloc_ready = 1'b1;
        step();
        bus4.alloc_ready = 1'b0;
        checks++;
        if (bus4.busy !== 4'b1011) begin failures++; $display("FAIL ooo_realloc_busy got=%b want=1011", bus4.busy); end
        checks++;
        if (bus4.count !== 3'd3) begin failures++; $display("FAIL ooo_realloc_count got=%0d want=3", bus4.count); end
    endtask

    task automatic test_simultaneous();
        // 1011 -> 0011
        bus4.free_valid = 1'b1;
        bus4.free_id    = 2'd3;
        step();
        checks++;
        if (bus4.busy !== 4'b0011) begin failures++; $display("FAIL simul_setup_busy got=%b want=0011", bus4.busy); end
        checks++;
        if (bus4.alloc_id !== 2'd2) begin failures++; $display("FAIL simul_pre_id got=%0d want=2", bus4.alloc_id); end
        bus4.alloc_ready = 1'b1;
        bus4.free_id     = 2'd0;
        step();
        bus4.alloc_ready = 1'b0;
        bus4.free_valid  = 1'b0;
        checks++;
        if (bus4.busy !== 4'b0110) begin failures++; $display("FAIL simul_busy got=%b want=0110", bus4.busy); end
        checks++;
        if (bus4.count !== 3'd2) begin failures++; $display("FAIL simul_count got=%0d want=2", bus4.count); end
        checks++;
        if (bus4.alloc_id !== 2'd0) begin failures++; $display("FAIL simul_next_id got=%0d want=0", bus4.alloc_id); end
    endtask

    task automatic test_full_free();
        // 0110 -> 0111 -> 1111
        bus4.alloc_ready = 1'b1;
        step();
        step();
        checks++;
        if ({bus4.full, bus4.alloc_valid} !== 2'b10) begin
            failures++; $display("FAIL fullfree_setup full/valid got=%b want=10", {bus4.full, bus4.alloc_valid});
        end
        bus4.free_valid = 1'b1;
        bus4.free_id    = 2'd3;
        step();
        bus4.alloc_ready = 1'b0;
        bus4.free_valid  = 1'b0;
        checks++;
        if (bus4.busy !== 4'b0111) begin failures++; $display("FAIL fullfree_busy got=%b want=0111", bus4.busy); end
        checks++;
        if (bus4.count !== 3'd3) begin failures++; $display("FAIL fullfree_count got=%0d want=3", bus4.count); end
        checks++;
        if ({bus4.alloc_valid, bus4.alloc_id} !== 3'b111) begin
            failures++; $display("FAIL fullfree_next valid/id got=%b want=111", {bus4.alloc_valid, bus4.alloc_id});
        end
    endtask

    task automatic test_illegal_free();
        // Legal free of 1: 0111 -> 0101, then an illegal free of 1.
        bus4.free_valid = 1'b1;
        bus4.free_id    = 2'd1;
        step();
        checks++;
        if ({bus4.busy, bus4.err_dfree} !== 5'b0101_0) begin
            failures++; $display("FAIL illegal_setup busy/err got=%b want=01010", {bus4.busy, bus4.err_dfree});
        end
        step();
        bus4.free_valid = 1'b0;
        checks++;
        if (bus4.busy !== 4'b0101) begin failures++; $display("FAIL illegal_busy got=%b want=0101", bus4.busy); end
        checks++;
        if (bus4.count !== 3'd2) begin failures++; $display("FAIL illegal_count got=%0d want=2", bus4.count); end
        checks++;
        if (bus4.err_dfree !== 1'b1) begin failures++; $display("FAIL illegal_err got=%b want=1", bus4.err_dfree); end

        // Clear together with another illegal free: set wins.
        bus4.err_clr    = 1'b1;
        bus4.free_valid = 1'b1;
        bus4.free_id    = 2'd3;
        step();
        bus4.free_valid = 1'b0;
        checks++;
        if (bus4.err_dfree !== 1'b1) begin failures++; $display("FAIL illegal_set_wins got=%b want=1", bus4.err_dfree); end
        step();
        bus4.err_clr = 1'b0;
        checks++;
        if (bus4.err_dfree !== 1'b0) begin failures++; $display("FAIL illegal_clear got=%b want=0", bus4.err_dfree); end

        // N=6: free of 5 while not busy, then out-of-range 6.
        bus6.free_valid = 1'b1;
        bus6.free_id    = 3'd5;
        step();
        bus6.free_valid = 1'b0;
        bus6.err_clr    = 1'b1;
        checks++;
        if ({bus6.busy, bus6.count, bus6.err_dfree} !== {6'b0, 4'd0, 1'b1}) begin
            failures++; $display("FAIL n6_free5 busy/count/err got=%b/%0d/%b want=000000/0/1", bus6.busy, bus6.count, bus6.err_dfree);
        end
        step();
        bus6.err_clr    = 1'b0;
        bus6.free_valid = 1'b1;
        bus6.free_id    = 3'd6;
        checks++;
        if (bus6.err_dfree !== 1'b0) begin failures++; $display("FAIL n6_clear got=%b want=0", bus6.err_dfree); end
        step();
        bus6.free_valid = 1'b0;
        checks++;
        if ({bus6.busy, bus6.count, bus6.err_dfree} !== {6'b0, 4'd0, 1'b1}) begin
            failures++; $display("FAIL n6_free6 busy/count/err got=%b/%0d/%b want=000000/0/1", bus6.busy, bus6.count, bus6.err_dfree);
        end

        // Leave a pending error on the N=4 instance for the reset test.
        bus4.free_valid = 1'b1;
        bus4.free_id    = 2'd3;
        step();
        bus4.free_valid = 1'b0;
        checks++;
        if (bus4.err_dfree !== 1'b1) begin failures++; $display("FAIL illegal_rearm got=%b want=1", bus4.err_dfree); end
    endtask

    task automatic test_reset_mid();
        checks++;
        if ({bus4.busy, bus4.alloc_id} !== 6'b0101_01) begin
            failures++; $display("FAIL rstmid_setup busy/id got=%b want=010101", {bus4.busy, bus4.alloc_id});
        end
        bus4.alloc_ready = 1'b1;
        #3;
        aresetn = 1'b0;
        #1;
        checks++;
        if (bus4.busy !== 4'b0000) begin failures++; $display("FAIL rstmid_busy got=%b want=0000", bus4.busy); end
        checks++;
        if ({bus4.count, bus4.empty} !== 4'b000_1) begin
            failures++; $display("FAIL rstmid_count/empty got=%b want=0001", {bus4.count, bus4.empty});
        end
        checks++;
        if ({bus4.alloc_id, bus4.err_dfree, bus6.err_dfree} !== 4'b00_0_0) begin
            failures++; $display("FAIL rstmid_id/err4/err6 got=%b want=0000", {bus4.alloc_id, bus4.err_dfree, bus6.err_dfree});
        end
        bus4.alloc_ready = 1'b0;
        step();
        aresetn = 1'b1;
        step();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_fill();
        test_ooo_release();
        test_simultaneous();
        test_full_free();
        test_illegal_free();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
